// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: drives per-stage en/flush,
// sequences multi-cycle EX ops and counts stalled cycles (saturating).
module pipe_hazard_ctrl #(
   parameter int REG_W     = 5,
   parameter int MC_CYCLES = 4,
   parameter int CNT_W     = 32
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_branch_taken,
   input  logic             ex_mc_start,
   input  logic             mem_wait,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_flush,
   output logic             mem_wb_flush,
   output logic             mc_busy,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int MCW = $clog2(MC_CYCLES + 1);

   typedef enum logic {RUN, MC_BUSY} state_t;

   state_t           state;
   logic [MCW-1:0]   mc_cnt;
   logic             load_use;
   logic             mc_go;

   assign load_use = ex_mem_read && (ex_rd != '0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                      (id_use_rs2 && (id_rs2 == ex_rd)));

   // Only a start that survives every higher-priority event enters MC_BUSY.
   assign mc_go = (state == RUN) && !mem_wait && !ex_branch_taken &&
                  !load_use && ex_mc_start;

   always_comb begin
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_ex_en     = 1'b1;
      ex_mem_en    = 1'b1;
      mem_wb_en    = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      mem_wb_flush = 1'b0;
      if (mem_wait) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_en     = 1'b0;
         ex_mem_en    = 1'b0;
         mem_wb_flush = 1'b1;
      end else if (state == MC_BUSY) begin
         // Counter at zero is the release cycle: EX/MEM captures the result.
         if (mc_cnt != '0) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
         end
      end else if (ex_branch_taken) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (load_use) begin
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         id_ex_flush = 1'b1;
      end else if (ex_mc_start) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_en     = 1'b0;
         ex_mem_flush = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state   <= RUN;
         mc_cnt  <= '0;
         mc_busy <= 1'b0;
      end else if (!mem_wait) begin
         case (state)
            RUN: begin
               if (mc_go) begin
                  state   <= MC_BUSY;
                  mc_cnt  <= MCW'(MC_CYCLES - 2);
                  mc_busy <= 1'b1;
               end
            end
            MC_BUSY: begin
               if (mc_cnt == '0) begin
                  state   <= RUN;
                  mc_busy <= 1'b0;
               end else begin
                  mc_cnt <= mc_cnt - MCW'(1);
               end
            end
            default: begin
               state   <= RUN;
               mc_busy <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n)
         stall_cnt <= '0;
      else if (!pc_en && (stall_cnt != {CNT_W{1'b1}}))
         stall_cnt <= stall_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; a second instance with a 4-bit counter
// shares the stimulus to exercise stall-counter saturation.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       arst_n;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
   logic       ex_mc_start, mem_wait;
   logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
   logic       mc_busy;
   logic [31:0] stall_cnt;
   logic       s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en;
   logic       s_if_id_flush, s_id_ex_flush, s_ex_mem_flush, s_mem_wb_flush;
   logic       s_mc_busy;
   logic [3:0] s_stall_cnt;

   int n_chk = 0;
   int n_err = 0;

   // {pc,if_id,id_ex,ex_mem,mem_wb en, if_id,id_ex,ex_mem,mem_wb flush}
   localparam logic [8:0] C_RUN = 9'b11111_0000;
   localparam logic [8:0] C_LU  = 9'b00111_0100;
   localparam logic [8:0] C_BR  = 9'b11111_1100;
   localparam logic [8:0] C_MC  = 9'b00011_0010;
   localparam logic [8:0] C_MW  = 9'b00001_0001;

   logic [8:0] ctl;
   assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                 if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

   always #5 clk = ~clk;

   pipe_hazard_ctrl dut (
      .clk(clk), .arst_n(arst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
      .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start),
      .mem_wait(mem_wait), .pc_en(pc_en), .if_id_en(if_id_en),
      .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
      .mc_busy(mc_busy), .stall_cnt(stall_cnt)
   );

   pipe_hazard_ctrl #(.CNT_W(4)) dut_sat (
      .clk(clk), .arst_n(arst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
      .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start),
      .mem_wait(mem_wait), .pc_en(s_pc_en), .if_id_en(s_if_id_en),
      .id_ex_en(s_id_ex_en), .ex_mem_en(s_ex_mem_en), .mem_wb_en(s_mem_wb_en),
      .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
      .ex_mem_flush(s_ex_mem_flush), .mem_wb_flush(s_mem_wb_flush),
      .mc_busy(s_mc_busy), .stall_cnt(s_stall_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs change here.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      arst_n = 1'b0;
      {id_rs1, id_rs2, ex_rd} = '0;
      {id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken} = '0;
      {ex_mc_start, mem_wait} = '0;
      #2;
      chk("rst_ctl", 32'(ctl), 32'(C_RUN));
      chk("rst_busy", 32'(mc_busy), 0);
      chk("rst_cnt", stall_cnt, 0);
      #10 arst_n = 1'b1;
      cyc();

      // load-use on rs2
      ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1; #1;
      chk("lu_ctl", 32'(ctl), 32'(C_LU));
      chk("lu_busy", 32'(mc_busy), 0);
      cyc();
      ex_mem_read = 0; #1;
      chk("lu_next_ctl", 32'(ctl), 32'(C_RUN));
      chk("lu_cnt", stall_cnt, 1);

      // load into x0 never stalls; unused source never stalls
      ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1; id_use_rs2 = 0; #1;
      chk("x0_ctl", 32'(ctl), 32'(C_RUN));
      ex_rd = 7; id_rs1 = 7; id_use_rs1 = 0; #1;
      chk("nouse_ctl", 32'(ctl), 32'(C_RUN));
      id_use_rs1 = 1; #1;
      chk("lu_rs1_ctl", 32'(ctl), 32'(C_LU));

      // branch outranks load-use and mc start
      ex_branch_taken = 1; ex_mc_start = 1; #1;
      chk("br_ctl", 32'(ctl), 32'(C_BR));
      cyc();
      chk("br_cnt", stall_cnt, 1);
      chk("br_busy", 32'(mc_busy), 0);
      {ex_mem_read, ex_branch_taken, ex_mc_start, id_use_rs1} = '0;

      // multi-cycle op; branch+load-use in cycle 1 must be ignored
      ex_mc_start = 1; #1;
      chk("mc0_ctl", 32'(ctl), 32'(C_MC));
      chk("mc0_busy", 32'(mc_busy), 0);
      cyc();
      ex_mc_start = 0; ex_branch_taken = 1; ex_mem_read = 1; id_use_rs1 = 1; #1;
      chk("mc1_ctl", 32'(ctl), 32'(C_MC));
      chk("mc1_busy", 32'(mc_busy), 1);
      cyc();
      {ex_branch_taken, ex_mem_read, id_use_rs1} = '0; #1;
      chk("mc2_ctl", 32'(ctl), 32'(C_MC));
      cyc();
      chk("mc3_ctl", 32'(ctl), 32'(C_RUN));
      chk("mc3_busy", 32'(mc_busy), 1);
      cyc();
      chk("mc4_ctl", 32'(ctl), 32'(C_RUN));
      chk("mc4_busy", 32'(mc_busy), 0);
      chk("mc_cnt", stall_cnt, 4);

      // mem_wait for 2 cycles inside MC_BUSY freezes the counter
      ex_mc_start = 1; #1;
      chk("mw0_ctl", 32'(ctl), 32'(C_MC));
      cyc();
      ex_mc_start = 0; #1;
      chk("mw1_ctl", 32'(ctl), 32'(C_MC));
      cyc();
      mem_wait = 1; #1;
      chk("mw2_ctl", 32'(ctl), 32'(C_MW));
      chk("mw2_busy", 32'(mc_busy), 1);
      cyc();
      chk("mw3_ctl", 32'(ctl), 32'(C_MW));
      cyc();
      mem_wait = 0; #1;
      chk("mw4_ctl", 32'(ctl), 32'(C_MC));
      cyc();
      chk("mw5_ctl", 32'(ctl), 32'(C_RUN));
      chk("mw5_busy", 32'(mc_busy), 1);
      cyc();
      chk("mw6_busy", 32'(mc_busy), 0);
      chk("mw_cnt", stall_cnt, 9);

      // mem_wait in RUN suppresses an mc start
      mem_wait = 1; ex_mc_start = 1; #1;
      chk("mwrun_ctl", 32'(ctl), 32'(C_MW));
      cyc();
      mem_wait = 0; ex_mc_start = 0; #1;
      chk("mwrun_busy", 32'(mc_busy), 0);
      chk("mwrun_ctl2", 32'(ctl), 32'(C_RUN));
      chk("mwrun_cnt", stall_cnt, 10);

      // asynchronous reset mid-MC_BUSY
      ex_mc_start = 1;
      cyc();
      ex_mc_start = 0; #1;
      chk("ar_busy_pre", 32'(mc_busy), 1);
      #2 arst_n = 1'b0;
      #1;
      chk("ar_busy", 32'(mc_busy), 0);
      chk("ar_cnt", stall_cnt, 0);
      chk("ar_ctl", 32'(ctl), 32'(C_RUN));
      #2 arst_n = 1'b1;
      cyc();
      chk("ar_post_ctl", 32'(ctl), 32'(C_RUN));
      chk("ar_post_busy", 32'(mc_busy), 0);
      chk("ar_post_cnt", stall_cnt, 0);

      // 4-bit counter saturates at 15
      mem_wait = 1;
      repeat (14) cyc();
      chk("sat_14", 32'(s_stall_cnt), 14);
      repeat (6) cyc();
      chk("sat_15", 32'(s_stall_cnt), 15);
      chk("sat_wide", stall_cnt, 20);
      mem_wait = 0;
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1);
   end

endmodule
